// File: rtl/data_packer.sv
// data_packer: gathers OUT_WIDTH/IN_WIDTH narrow beats into one wide word.
// Lane 0 is the first beat; last closes a word early with zero upper lanes.
module data_packer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128,
  localparam int RATIO = OUT_WIDTH / IN_WIDTH,
  localparam int CNT_W = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_unpacked_write_req,
  input  logic [IN_WIDTH-1:0]  s_unpacked_write_data,
  input  logic                 s_unpacked_write_last,
  output logic                 s_unpacked_write_ready,
  output logic                 m_packed_write_req,
  output logic [OUT_WIDTH-1:0] m_packed_write_data,
  output logic [CNT_W-1:0]     m_packed_write_count,
  input  logic                 m_packed_write_ready,
  output logic                 busy
);

  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [LW-1:0]        lane_cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic                 out_vld;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_cnt;
  logic                 accept;
  logic                 last_lane;
  logic                 complete;
  logic                 drain;

  // Input may move whenever the output slot is empty or being drained
  assign s_unpacked_write_ready = !out_vld || m_packed_write_ready;

  assign accept    = s_unpacked_write_req && s_unpacked_write_ready;
  assign last_lane = (lane_cnt == LW'(RATIO - 1));
  assign complete  = accept && (last_lane || s_unpacked_write_last);
  assign drain     = out_vld && m_packed_write_ready;

  // Accumulator with the incoming beat dropped into its lane
  always_comb begin
    merged = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_cnt == LW'(i)) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = s_unpacked_write_data;
      end
    end
  end

  generate
    if (RATIO > 1) begin : g_lane
      // Lane pointer: advances per beat, rewinds on word completion
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lane_cnt <= '0;
        end else if (complete) begin
          lane_cnt <= '0;
        end else if (accept) begin
          lane_cnt <= lane_cnt + LW'(1);
        end
      end
    end else begin : g_tie
      assign lane_cnt = '0;
    end
  endgenerate

  // Partial-word accumulator, cleared so unwritten lanes read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (complete) begin
      acc <= '0;
    end else if (accept) begin
      acc <= merged;
    end
  end

  // Output slot valid: completion wins over a same-cycle drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
    end else if (complete) begin
      out_vld <= 1'b1;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end

  // Output word and lane count; held while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_cnt  <= '0;
    end else if (complete) begin
      out_data <= merged;
      out_cnt  <= CNT_W'(lane_cnt) + CNT_W'(1);
    end
  end

  assign m_packed_write_req   = out_vld;
  assign m_packed_write_data  = out_data;
  assign m_packed_write_count = out_cnt;
  assign busy = (lane_cnt != '0) || out_vld;

endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: scoreboard bench for data_packer (64 -> 128).
// Words are queued at completion and popped when the DUT hands them off.
module tb_data_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_req;
  logic [63:0]  s_data;
  logic         s_last;
  logic         s_ready;
  logic         m_req;
  logic [127:0] m_data;
  logic [1:0]   m_count;
  logic         m_ready;
  logic         busy;

  data_packer #(.IN_WIDTH(64), .OUT_WIDTH(128)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_unpacked_write_req   (s_req),
    .s_unpacked_write_data  (s_data),
    .s_unpacked_write_last  (s_last),
    .s_unpacked_write_ready (s_ready),
    .m_packed_write_req     (m_req),
    .m_packed_write_data    (m_data),
    .m_packed_write_count   (m_count),
    .m_packed_write_ready   (m_ready),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   c;
  } word_t;

  word_t        sb[$];
  logic [63:0]  seq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           mr_mode = 0;
  logic         mdl_vld = 1'b0;
  int           mdl_lane = 0;
  logic [127:0] mdl_acc = '0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rq, input logic [63:0] d,
                       input logic lst, output logic acc_o);
    logic         mr;
    logic         exp_rdy;
    logic         drain;
    logic         nvld;
    logic [127:0] merged;
    logic [63:0]  ref_beat;
    word_t        w;
    case (mr_mode)
      0:       mr = 1'b0;
      1:       mr = 1'b1;
      2:       mr = cyc[0];
      default: mr = 1'($urandom_range(0, 1));
    endcase
    s_req = rq; s_data = d; s_last = lst; m_ready = mr;
    @(negedge clk);
    exp_rdy = !mdl_vld || mr;
    chk("s_ready", 128'(s_ready), 128'(exp_rdy));
    chk("m_req", 128'(m_req), 128'(mdl_vld));
    chk("busy", 128'(busy), 128'((mdl_lane != 0) || mdl_vld));
    drain = mdl_vld && mr;
    if (mdl_vld && sb.size() > 0) begin
      chk("m_data", m_data, sb[0].d);
      chk("m_count", 128'(m_count), 128'(sb[0].c));
      if (drain) begin
        w = sb.pop_front();
        for (int i = 0; i < int'(m_count) && i < 2; i++) begin
          ref_beat = (seq.size() > 0) ? seq.pop_front() : 64'hx;
          chk("roundtrip", 128'(m_data[i*64 +: 64]), 128'(ref_beat));
        end
      end
    end
    acc_o = rq && exp_rdy;
    nvld = mdl_vld && !drain;
    if (acc_o) begin
      seq.push_back(d);
      merged = mdl_acc;
      merged[mdl_lane*64 +: 64] = d;
      if (mdl_lane == 1 || lst) begin
        w.d = merged;
        w.c = 2'(mdl_lane + 1);
        sb.push_back(w);
        mdl_lane = 0;
        mdl_acc = '0;
        nvld = 1'b1;
      end else begin
        mdl_lane++;
        mdl_acc = merged;
      end
    end
    mdl_vld = nvld;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic lst);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      cycle(1'b1, d, lst, a);
      tries++;
    end
    chk("send_accept", 128'(a), 128'(1));
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 1'b0, a);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_req"}, 128'(m_req), 128'(0));
    chk({tag, "_data"}, m_data, 128'(0));
    chk({tag, "_cnt"}, 128'(m_count), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rdy"}, 128'(s_ready), 128'(1));
  endtask

  initial begin
    logic a;
    reset = 1'b0;
    s_req = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    #3;
    chk_cleared("rst");
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("rst_hold");
    reset = 1'b1;

    // back-to-back full words, every beat accepted first try
    mr_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 64'(i), 1'b0, a);
      chk("b2b_acc", 128'(a), 128'(1));
    end
    idle(2);

    // partial word via last, then next beat in lane 0
    send(64'hA, 1'b1);
    send(64'hB, 1'b1);
    idle(2);

    // backpressure: third beat held off until ready rises
    mr_mode = 0;
    send(64'h11, 1'b0);
    send(64'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'h33, 1'b0, a);
      chk("bp_hold", 128'(a), 128'(0));
    end
    mr_mode = 1;
    cycle(1'b1, 64'h33, 1'b0, a);
    chk("bp_release", 128'(a), 128'(1));
    send(64'h44, 1'b0);
    idle(2);

    // toggling ready under a continuous stream
    mr_mode = 2;
    for (int i = 0; i < 20; i++) send(64'h100 + 64'(i), 1'b0);
    mr_mode = 1;
    idle(2);

    // reset mid-operation after a lone beat
    send(64'h5, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_cleared("amid");
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("amid_hold");
    reset = 1'b1;
    mdl_vld = 1'b0; mdl_lane = 0; mdl_acc = '0;
    sb.delete(); seq.delete();
    send(64'h6, 1'b0);
    send(64'h7, 1'b0);
    chk("post_rst_word", m_data, {64'h7, 64'h6});
    idle(2);

    // random stream with random ready and occasional last
    mr_mode = 3;
    for (int i = 0; i < 60; i++) begin
      send({$urandom, $urandom}, ($urandom_range(0, 4) == 0));
    end
    send({$urandom, $urandom}, 1'b1);
    mr_mode = 1;
    idle(3);
    chk("sb_left", 128'(sb.size()), 128'(0));
    chk("seq_left", 128'(seq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
